ysyx_22041211_ifu: RTL and testbench
====================================

Name: ysyx_22041211_ifu

Overview:
Instruction fetch unit for the NPC core, directly upstream of decode and of the immediate sign-extension stage. Holds the PC and issues one instruction-memory request at a time over a valid/ready handshake. Captures the returned word and presents inst/pc to decode over a valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards any stale fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction word substituted on a fetch fault (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-low (0 = reset)
redirect_valid  input  1  one-cycle pulse: load redirect_pc, kill current fetch
redirect_pc  input  32  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (= pc)
imem_rsp_valid  input  1  response valid; honoured only in S_WAIT
imem_rsp_data  input  32  fetched word
imem_rsp_err  input  1  access fault on this response
id_valid  output  1  instruction valid to decode
id_ready  input  1  decode accepts
id_inst  output  32  instruction word
id_pc  output  32  pc of id_inst
id_fault  output  1  fetch fault or misaligned pc on id_inst

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=S_REQ, drop=0, id_valid=0, id_inst=0, id_pc=0, id_fault=0. imem_req_valid=0 while rst=0.
- imem_req_valid = (state==S_REQ) && pc[1:0]==0. imem_req_addr = pc. Both come straight from registers, with no combinational path from inputs.
- At most one request outstanding. A response is assumed no earlier than the cycle after acceptance.
- S_REQ, pc[1:0]!=0: no request. Next cycle id_valid=1, id_fault=1, id_inst=NOP_INST, id_pc=pc, state goes to S_HOLD.
- S_REQ, request fires (valid&&ready): state goes to S_WAIT.
- S_WAIT, imem_rsp_valid=1 and drop=0: id_inst = rsp_err ? NOP_INST : rsp_data. id_fault=rsp_err, id_pc=pc, id_valid=1. pc <= pc+4, wrapping mod 2^32. State goes to S_HOLD.
- S_WAIT, imem_rsp_valid=1 and drop=1: response discarded, drop cleared, state goes to S_REQ. pc is unchanged and already holds the redirect target.
- S_HOLD: outputs held stable while id_valid && !id_ready. When id_ready=1, the transfer completes, id_valid <= 0 and state goes to S_REQ.
- Fetch-to-decode latency: one request cycle (minimum), then the response cycle, then id_valid on the next edge. Throughput is at most one instruction per 3 cycles, with no request overlap.
- Redirect has priority over the normal pc update in every state. pc <= redirect_pc.
  - S_REQ: if the request fires in the same cycle, state goes to S_WAIT with drop=1. Otherwise state stays S_REQ, and the new pc is requested next cycle.
  - S_WAIT: drop <= 1. If rsp_valid arrives the same cycle, that response is discarded and state goes directly to S_REQ with drop=0.
  - S_HOLD: id_valid <= 0 and state goes to S_REQ. If id_ready=1 in that same cycle, the transfer still counts. Decode is responsible for killing it.
- A misaligned redirect_pc is not fetched. It produces the fault path above.
- Reset mid-fetch: all state is abandoned. A late imem_rsp_valid seen in S_REQ or S_HOLD is ignored.
- id_* registers update only on capture. Values are don't-care while id_valid=0 but must not toggle spuriously.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle-later rsp 0x00500093 -> imem_req_addr=0x80000000. Then id_valid=1, id_inst=0x00500093, id_pc=0x80000000. The next request goes to 0x80000004.
- id_ready held 0 for 5 cycles after capture -> id_* stable, no new imem request. Raise id_ready -> exactly one transfer, then a request to 0x80000004.
- redirect_valid with redirect_pc=0x80000100 while in S_WAIT, rsp 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never reaches decode. The next request goes to 0x80000100.
- Response with imem_rsp_err=1 at pc 0x80000008 -> id_fault=1, id_inst=0x00000013, id_pc=0x80000008. pc advances to 0x8000000C.
- Redirect to 0x80000102 -> no imem request. id_valid=1, id_fault=1, id_pc=0x80000102.
- rst asserted while in S_WAIT, then released with a stray rsp_valid -> pc=0x80000000, stray response ignored, fresh request to 0x80000000. Also covers wrap: RESET_PC=32'hFFFFFFFC, first capture -> next request addr=0x00000000.

Source files
------------

// File: rtl/ysyx_22041211_ifu.sv
// ysyx_22041211_ifu: instruction fetch unit holding the PC and issuing one imem
// request at a time over a valid/ready handshake.
// Ports: clk, rst (async, active-low), redirect_valid/redirect_pc,
//        imem_req_valid/ready/addr, imem_rsp_valid/data/err,
//        id_valid/ready/inst/pc/fault to decode.
module ysyx_22041211_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_fault
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        armed;
  logic        drop;
  logic        drop_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic        aligned;
  logic        fire;
  logic        cap_rsp;
  logic        cap_flt;
  logic        clr;

  assign aligned = (pc[1:0] == 2'b00);
  assign fire    = imem_req_valid && imem_req_ready;

  // armed is a registered reset-release flag, so the request stays low
  // during reset without any combinational path from rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
      pc    <= RESET_PC;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      pc    <= pc_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    drop_nx  = drop;
    cap_rsp  = 1'b0;
    cap_flt  = 1'b0;
    clr      = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          if (fire) begin
            state_nx = S_WAIT;
            drop_nx  = 1'b1;
          end
        end else if (armed && !aligned) begin
          cap_flt  = 1'b1;
          state_nx = S_HOLD;
        end else if (fire) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop || redirect_valid) begin
            state_nx = S_REQ;
            drop_nx  = 1'b0;
          end else begin
            cap_rsp  = 1'b1;
            state_nx = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_nx = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || id_ready) begin
          clr      = 1'b1;
          state_nx = S_REQ;
        end
      end
      default: begin
        state_nx = S_REQ;
        drop_nx  = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_nx = pc;
    if (redirect_valid) begin
      pc_nx = redirect_pc;
    end else if (cap_rsp) begin
      pc_nx = pc + 32'd4;
    end
  end

  always_comb begin
    imem_req_valid = armed && (state == S_REQ) && aligned;
    imem_req_addr  = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
      id_fault <= 1'b0;
    end else if (cap_rsp) begin
      id_valid <= 1'b1;
      id_inst  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
      id_pc    <= pc;
      id_fault <= imem_rsp_err;
    end else if (cap_flt) begin
      id_valid <= 1'b1;
      id_inst  <= NOP_INST;
      id_pc    <= pc;
      id_fault <= 1'b1;
    end else if (clr) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// tb_ysyx_22041211_ifu: directed bench for the fetch unit, plus a second
// instance with RESET_PC at the top of memory to exercise pc wrap.
module tb_ysyx_22041211_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'h0;
  logic        w_id_valid;
  logic [31:0] w_id_inst;
  logic [31:0] w_id_pc;
  logic        w_id_fault;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ysyx_22041211_ifu u_dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_fault(id_fault)
  );

  ysyx_22041211_ifu #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk(clk),
    .rst(rst),
    .redirect_valid(1'b0),
    .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid),
    .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data),
    .imem_rsp_err(1'b0),
    .id_valid(w_id_valid),
    .id_ready(1'b0),
    .id_inst(w_id_inst),
    .id_pc(w_id_pc),
    .id_fault(w_id_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nedge;
    @(negedge clk);
  endtask

  initial begin
    // reset state
    nedge();
    nedge();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_fault", {31'b0, id_fault}, 32'h0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);
    chk("w_rst_addr", w_req_addr, 32'hFFFF_FFFC);

    // basic fetch
    rst = 1'b1;
    imem_req_ready = 1'b1;
    nedge();
    chk("f1_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("f1_addr", imem_req_addr, 32'h8000_0000);
    chk("w_req_valid", {31'b0, w_req_valid}, 32'h1);
    nedge();
    chk("f1_wait_req", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0050_0093;
    w_rsp_valid = 1'b1;
    w_rsp_data = 32'h0000_0013;
    nedge();
    imem_rsp_valid = 1'b0;
    w_rsp_valid = 1'b0;
    chk("f1_id_valid", {31'b0, id_valid}, 32'h1);
    chk("f1_id_inst", id_inst, 32'h0050_0093);
    chk("f1_id_pc", id_pc, 32'h8000_0000);
    chk("f1_id_fault", {31'b0, id_fault}, 32'h0);
    chk("f1_next_addr", imem_req_addr, 32'h8000_0004);
    chk("w_id_pc", w_id_pc, 32'hFFFF_FFFC);
    chk("w_wrap_addr", w_req_addr, 32'h0000_0000);

    // decode stall
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("st_id_valid", {31'b0, id_valid}, 32'h1);
      chk("st_id_inst", id_inst, 32'h0050_0093);
      chk("st_id_pc", id_pc, 32'h8000_0000);
      chk("st_req_valid", {31'b0, imem_req_valid}, 32'h0);
    end
    id_ready = 1'b1;
    nedge();
    id_ready = 1'b0;
    chk("xf_id_valid", {31'b0, id_valid}, 32'h0);
    chk("xf_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("xf_addr", imem_req_addr, 32'h8000_0004);

    // redirect while waiting, stale response dropped
    nedge();
    chk("rw_wait_req", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    nedge();
    redirect_valid = 1'b0;
    chk("rw_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rw_addr", imem_req_addr, 32'h8000_0100);
    nedge();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    nedge();
    imem_rsp_valid = 1'b0;
    chk("rw_drop_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rw_req_valid2", {31'b0, imem_req_valid}, 32'h1);
    chk("rw_addr2", imem_req_addr, 32'h8000_0100);
    nedge();
    chk("rw_fire_id_valid", {31'b0, id_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0010_0113;
    nedge();
    imem_rsp_valid = 1'b0;
    chk("rt_id_inst", id_inst, 32'h0010_0113);
    chk("rt_id_pc", id_pc, 32'h8000_0100);
    chk("rt_addr", imem_req_addr, 32'h8000_0104);

    // redirect in hold
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0008;
    nedge();
    redirect_valid = 1'b0;
    chk("rh_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rh_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("rh_addr", imem_req_addr, 32'h8000_0008);

    // access fault response
    nedge();
    imem_rsp_valid = 1'b1;
    imem_rsp_err = 1'b1;
    imem_rsp_data = 32'h1234_5678;
    nedge();
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    chk("er_id_valid", {31'b0, id_valid}, 32'h1);
    chk("er_id_fault", {31'b0, id_fault}, 32'h1);
    chk("er_id_inst", id_inst, 32'h0000_0013);
    chk("er_id_pc", id_pc, 32'h8000_0008);
    chk("er_addr", imem_req_addr, 32'h8000_000C);
    id_ready = 1'b1;
    nedge();
    id_ready = 1'b0;
    chk("er_next_req", {31'b0, imem_req_valid}, 32'h1);
    chk("er_next_addr", imem_req_addr, 32'h8000_000C);

    // misaligned redirect
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    nedge();
    redirect_valid = 1'b0;
    chk("ma_req_valid", {31'b0, imem_req_valid}, 32'h0);
    nedge();
    chk("ma_id_valid", {31'b0, id_valid}, 32'h1);
    chk("ma_id_fault", {31'b0, id_fault}, 32'h1);
    chk("ma_id_pc", id_pc, 32'h8000_0102);
    chk("ma_id_inst", id_inst, 32'h0000_0013);
    chk("ma_req_valid2", {31'b0, imem_req_valid}, 32'h0);

    // reset mid-fetch
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    nedge();
    redirect_valid = 1'b0;
    chk("rs_addr", imem_req_addr, 32'h8000_0200);
    nedge();
    chk("rs_wait_req", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rs_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rs_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rs_addr_reset", imem_req_addr, 32'h8000_0000);
    nedge();
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0BAD;
    nedge();
    imem_rsp_valid = 1'b0;
    chk("rs_stray_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rs_req_valid2", {31'b0, imem_req_valid}, 32'h1);
    chk("rs_addr2", imem_req_addr, 32'h8000_0000);
    nedge();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0093;
    nedge();
    imem_rsp_valid = 1'b0;
    chk("rs_id_inst", id_inst, 32'h0000_0093);
    chk("rs_id_pc", id_pc, 32'h8000_0000);
    chk("rs_next_addr", imem_req_addr, 32'h8000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
